weight_scan_rx: RTL and testbench
=================================

// Module: weight_scan_rx
// PURPOSE
//  Receiving end of the FIR weight scan-out chain. Drives scan_en, deserializes the 1-bit scan stream
//  (26-bit weights, LSB first) into parallel words and presents them on a valid/ready stream to the
//  debug/readback controller. Pauses the scan only at word boundaries when the output FIFO is full.
// PARAMETERS
//  WORDS  256  number of 26-bit words per scan (equals FIR TAPS)
//  W      26   bits per word
//  LAT    1    clocks from scan_en sampled high to the matching bit valid on scan_in (>=1)
//  DEPTH  4    output FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1   core clock (same clock as the FIR)
//  rst_n      in   1   synchronous reset, active low
//  start      in   1   one-cycle pulse: begin a full scan; ignored unless busy=0
//  busy       out  1   high from the cycle after accepted start until done
//  done       out  1   one-cycle pulse after the last word has been pushed into the FIFO
//  scan_en    out  1   scan shift enable to the FIR
//  scan_in    in   1   serial bit from FIR scan_out
//  wd_data    out  W   received word, sign bit at [W-1]
//  wd_idx     out  8   word index 0..WORDS-1 ($clog2(WORDS) wide)
//  wd_valid   out  1   FIFO non-empty
//  wd_ready   in   1   consumer accepts when wd_valid&&wd_ready
// BEHAVIOUR
//  Reset (rst_n=0 sampled at clk): busy=0, done=0, scan_en=0, wd_valid=0, wd_data=0, wd_idx=0,
//   FIFO empty, all counters 0, state IDLE. Reset mid-scan aborts; partial word discarded.
//  FSM: IDLE -start-> RUN; RUN -(all WORDS*W bits received)-> DRAIN_DONE (1 cycle, done=1) -> IDLE.
//  Issue side: bit counter iss (0..WORDS*W). scan_en=1 in RUN while iss<WORDS*W, except at a word
//   boundary (iss%W==0) scan_en=0 unless FIFO free slots > words in flight (issued but not pushed).
//   Never drop scan_en mid-word.
//  Receive side: en_d = scan_en delayed LAT clocks (shift reg). When en_d[LAT-1]=1, shift scan_in
//   into shreg MSB-side (shreg <= {scan_in, shreg[W-1:1]}), increment bit count; on W-th bit push
//   {shreg result, rx word index} into FIFO same cycle and clear bit count.
//  Pauses are transparent: en_d gating keeps bit alignment; no re-synchronization.
//  Push and pop in same cycle with FIFO full: both occur, occupancy unchanged. Push never sees a
//   full FIFO (guaranteed by issue rule); assertion flags violation.
//  done asserts the cycle after the final push; FIFO may still hold words, consumer drains freely.
//  start while busy: ignored. wd_ready low indefinitely: scan stalls at boundary, no data loss.
//  Latency: first word in FIFO W+LAT clocks after scan_en first rises; wd_valid next cycle.
// CONFIGURATION
//  `SCAN_RX_CHECKSUM_EN defined: adds output port chk [31:0]; cleared on accepted start, adds
//   sign-extended wd word at each FIFO push (wraps mod 2^32); valid/stable from done onward.
//  Not defined: no chk port, no adder; all other behaviour identical.
// STRUCTURE
//  weight_scan_pkg: WEIGHT_W=26, default WORDS=256, state enum {IDLE,RUN,DRAIN_DONE}, word typedef.
//  Sub-module scan_rx_fifo (sync FIFO, DEPTH x (W+idx)): push/pop/full/empty/count, sync reset.
//  Top holds FSM, issue counter, LAT delay line, deserializer, in-flight accounting.
// TESTING
//  1 Reset then start, WORDS=4, weights 26'h0000001,26'h3FFFFFF,26'h2000000,26'h1555555, ready=1
//    -> four words in order, idx 0..3, done one pulse, scan_en high exactly 104 cycles.
//  2 Same, wd_ready=0 for 200 cycles -> scan_en drops after DEPTH words, only at iss%26==0;
//    on ready, remaining words arrive uncorrupted.
//  3 LAT=3 model, random ready toggling -> every word matches model, no FIFO overflow assertion.
//  4 rst_n low during word 2 of a scan, then new start -> outputs at reset values, fresh scan
//    returns word 0 correctly, no stale partial word.
//  5 start pulsed while busy -> ignored; exactly one done per accepted start.
//  6 `SCAN_RX_CHECKSUM_EN, words 26'h3FFFFFF x4 -> chk=32'hFFFFFFFC at done.

Source files
------------

// File: rtl/weight_scan_rx_pkg.sv
// Shared types and defaults for the FIR weight scan-out receiver (package weight_scan_pkg).
package weight_scan_pkg;

  localparam int unsigned WEIGHT_W      = 26;
  localparam int unsigned DEFAULT_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    DRAIN_DONE = 2'd2
  } state_t;

  typedef logic [WEIGHT_W-1:0] weight_t;

endpackage

// File: rtl/weight_scan_rx_fifo.sv
// Synchronous FIFO buffering received {word, index} pairs toward the readback consumer.
module scan_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 34
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rd_q];

  // A push into a full FIFO is honoured only when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/weight_scan_rx.sv
// FIR weight scan receiver: drives scan_en, deserializes LSB-first words, streams {word, idx} out.
// Optional `SCAN_RX_CHECKSUM_EN adds a 32-bit running sum of sign-extended words on port chk.
module weight_scan_rx
  import weight_scan_pkg::*;
#(
  parameter int unsigned WORDS = DEFAULT_WORDS,
  parameter int unsigned W     = WEIGHT_W,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       scan_en,
  input  logic                       scan_in,
  output logic [W-1:0]               wd_data,
  output logic [$clog2(WORDS)-1:0]   wd_idx,
  output logic                       wd_valid,
  input  logic                       wd_ready
`ifdef SCAN_RX_CHECKSUM_EN
  ,output logic [31:0]               chk
`endif
);

  localparam int unsigned IW = $clog2(WORDS);
  localparam int unsigned BW = $clog2(W);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t         state_q, state_d;
  logic [IW:0]    iss_word_q, iss_word_d;
  logic [BW-1:0]  iss_bit_q, iss_bit_d;
  logic [BW-1:0]  rx_bit_q, rx_bit_d;
  logic [IW-1:0]  rx_idx_q, rx_idx_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [LAT-1:0] en_d_q, en_d_d;
  logic [W-1:0]   shreg_q, shreg_d;

  logic [W-1:0]   rx_word;
  logic [CW-1:0]  fifo_cnt;
  logic           accept, rx_en, push, last_push, room, word_start;
  logic           fifo_full, fifo_empty, pop;

  assign accept     = start && (state_q == IDLE);
  assign rx_en      = en_d_q[LAT-1];
  assign rx_word    = {scan_in, shreg_q[W-1:1]};
  assign push       = rx_en && (rx_bit_q == BW'(W - 1));
  assign last_push  = push && (rx_idx_q == IW'(WORDS - 1));
  // A new word may start only if every word already in flight plus this one will find a free slot.
  assign room       = (32'(fifo_cnt) + 32'(inflight_q)) < DEPTH;
  assign scan_en    = (state_q == RUN) && (iss_word_q < (IW + 1)'(WORDS)) &&
                      ((iss_bit_q != '0) || room);
  assign word_start = scan_en && (iss_bit_q == '0);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DRAIN_DONE);
  assign wd_valid   = !fifo_empty;
  assign pop        = wd_valid && wd_ready;

  generate
    if (LAT == 1) begin : g_lat1
      assign en_d_d = scan_en;
    end else begin : g_latn
      assign en_d_d = {en_d_q[LAT-2:0], scan_en};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    iss_word_d = iss_word_q;
    iss_bit_d  = iss_bit_q;
    rx_bit_d   = rx_bit_q;
    rx_idx_d   = rx_idx_q;
    shreg_d    = shreg_q;
    inflight_d = inflight_q + CW'(word_start) - CW'(push);

    if (scan_en) begin
      if (iss_bit_q == BW'(W - 1)) begin
        iss_bit_d  = '0;
        iss_word_d = iss_word_q + 1'b1;
      end else begin
        iss_bit_d = iss_bit_q + 1'b1;
      end
    end

    if (rx_en) begin
      shreg_d = rx_word;
      if (push) begin
        rx_bit_d = '0;
        rx_idx_d = rx_idx_q + 1'b1;
      end else begin
        rx_bit_d = rx_bit_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          iss_word_d = '0;
          iss_bit_d  = '0;
          rx_bit_d   = '0;
          rx_idx_d   = '0;
          inflight_d = '0;
        end
      end
      RUN:        if (last_push) state_d = DRAIN_DONE;
      DRAIN_DONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iss_word_q <= '0;
      iss_bit_q  <= '0;
      rx_bit_q   <= '0;
      rx_idx_q   <= '0;
      inflight_q <= '0;
      en_d_q     <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      iss_word_q <= iss_word_d;
      iss_bit_q  <= iss_bit_d;
      rx_bit_q   <= rx_bit_d;
      rx_idx_q   <= rx_idx_d;
      inflight_q <= inflight_d;
      en_d_q     <= en_d_d;
      shreg_q    <= shreg_d;
    end
  end

  scan_rx_fifo #(
    .DEPTH (DEPTH),
    .DW    (W + IW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({rx_word, rx_idx_q}),
    .pop_i       (pop),
    .pop_data_o  ({wd_data, wd_idx}),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full);

`ifdef SCAN_RX_CHECKSUM_EN
  logic [31:0] chk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= '0;
    end else if (push) begin
      chk_q <= chk_q + {{(32 - W){rx_word[W-1]}}, rx_word};
    end
  end

  assign chk = chk_q;
`endif

endmodule

// File: tb/tb_weight_scan_rx.sv
// Directed bench for weight_scan_rx: LAT=1 and LAT=3 instances, each fed by a scan-chain model.
module tb_weight_scan_rx;

  localparam int W  = 26;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start1, start3, scan_in1, scan_in3, ready1, ready3;
  logic          busy1, done1, scan_en1, valid1, busy3, done3, scan_en3, valid3;
  logic [W-1:0]  data1, data3;
  logic [1:0]    idx1, idx3;
`ifdef SCAN_RX_CHECKSUM_EN
  logic [31:0]   chk1, chk3;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] wts [2][NW];
  logic         hist [2][8];
  int           ptr [2];
  int           rx [2];
  int           en_cnt [2];
  int           done_cnt [2];
  logic         prev_en [2];

  weight_scan_rx #(.WORDS(NW), .W(W), .LAT(1), .DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .scan_en(scan_en1), .scan_in(scan_in1), .wd_data(data1), .wd_idx(idx1),
    .wd_valid(valid1), .wd_ready(ready1)
`ifdef SCAN_RX_CHECKSUM_EN
    , .chk(chk1)
`endif
  );

  weight_scan_rx #(.WORDS(NW), .W(W), .LAT(3), .DEPTH(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .scan_en(scan_en3), .scan_in(scan_in3), .wd_data(data3), .wd_idx(idx3),
    .wd_valid(valid3), .wd_ready(ready3)
`ifdef SCAN_RX_CHECKSUM_EN
    , .chk(chk3)
`endif
  );

  task automatic check(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  // FIR scan chain model plus output monitor, evaluated once per cycle at the falling edge.
  task automatic model_step(input int d, input logic en, input logic dn, input logic vld,
                            input logic rdy, input logic [W-1:0] dat, input logic [1:0] idx,
                            input int lat, output logic sin);
    logic [W-1:0] w;
    logic         b;
    if (rst_n && prev_en[d] && !en) check("scan_en_drop_on_boundary", (ptr[d] % W) == 0);
    if (en) en_cnt[d]++;
    if (dn) done_cnt[d]++;
    if (vld && rdy) begin
      check("no_extra_word", rx[d] < NW);
      if (rx[d] < NW) begin
        check("word_data", dat === wts[d][rx[d]]);
        check("word_idx", idx === 2'(rx[d]));
      end
      rx[d]++;
    end
    b = 1'b0;
    if (en && ptr[d] < NW * W) begin
      w = wts[d][ptr[d] / W];
      b = w[ptr[d] % W];
    end
    if (en) ptr[d]++;
    for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = b;
    sin = hist[d][lat];
    prev_en[d] = rst_n ? en : 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step(0, scan_en1, done1, valid1, ready1, data1, idx1, 1, scan_in1);
      model_step(1, scan_en3, done3, valid3, ready3, data3, idx3, 3, scan_in3);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input int d);
    ptr[d] = 0; rx[d] = 0; en_cnt[d] = 0; done_cnt[d] = 0;
    if (d == 0) start1 = 1'b1; else start3 = 1'b1;
    tick(1);
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_cnt[d] != 0) break;
      tick(1);
    end
    check("done_seen", done_cnt[d] == 1);
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; ready1 = 1'b1; ready3 = 1'b1;
    scan_in1 = 1'b0; scan_in3 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; rx[d] = 0; en_cnt[d] = 0; done_cnt[d] = 0; prev_en[d] = 1'b0;
      for (int i = 0; i < 8; i++) hist[d][i] = 1'b0;
    end
    wts[0][0] = 26'h0000001; wts[0][1] = 26'h3FFFFFF; wts[0][2] = 26'h2000000; wts[0][3] = 26'h1555555;
    wts[1][0] = 26'h0ABCDEF; wts[1][1] = 26'h1234567; wts[1][2] = 26'h3000001; wts[1][3] = 26'h0000000;

    tick(3);
    check("rst_busy", busy1 === 1'b0);
    check("rst_done", done1 === 1'b0);
    check("rst_scan_en", scan_en1 === 1'b0);
    check("rst_valid", valid1 === 1'b0);
    check("rst_data", data1 === 26'h0);
    check("rst_idx", idx1 === 2'h0);
    rst_n = 1'b1;
    tick(2);

    // Basic scan, consumer always ready
    start_scan(0);
    check("t1_busy_after_start", busy1 === 1'b1);
    wait_done(0, 300);
    check("t1_words", rx[0] == NW);
    check("t1_scan_en_cycles", en_cnt[0] == NW * W);
    check("t1_idle", busy1 === 1'b0);

    // Consumer stalled: FIFO (2 deep) fills and scan pauses at the word boundary
    ready1 = 1'b0;
    start_scan(0);
    tick(200);
    check("t2_stall_en_cycles", en_cnt[0] == 2 * W);
    check("t2_stall_scan_en", scan_en1 === 1'b0);
    check("t2_stall_valid", valid1 === 1'b1);
    check("t2_stall_head_data", data1 === 26'h0000001);
    check("t2_stall_head_idx", idx1 === 2'h0);
    check("t2_stall_busy", busy1 === 1'b1);
    check("t2_no_done", done_cnt[0] == 0);
    ready1 = 1'b1;
    wait_done(0, 400);
    check("t2_words", rx[0] == NW);
    check("t2_scan_en_cycles", en_cnt[0] == NW * W);

    // LAT=3 with random consumer readiness
    start_scan(1);
    for (int i = 0; i < 300; i++) begin
      ready3 = 1'($urandom_range(0, 1));
      tick(1);
    end
    ready3 = 1'b1;
    wait_done(1, 400);
    check("t3_words", rx[1] == NW);
    check("t3_scan_en_cycles", en_cnt[1] == NW * W);

    // Reset in the middle of word 1, then a fresh scan
    start_scan(0);
    tick(40);
    check("t4_mid_scan_busy", busy1 === 1'b1);
    rst_n = 1'b0;
    tick(1);
    check("t4_rst_busy", busy1 === 1'b0);
    check("t4_rst_scan_en", scan_en1 === 1'b0);
    check("t4_rst_valid", valid1 === 1'b0);
    check("t4_rst_data", data1 === 26'h0);
    rst_n = 1'b1;
    tick(2);
    start_scan(0);
    wait_done(0, 300);
    check("t4_words", rx[0] == NW);

    // Start pulsed while busy is ignored
    start_scan(0);
    tick(10);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    wait_done(0, 300);
    tick(20);
    check("t5_single_done", done_cnt[0] == 1);
    check("t5_words", rx[0] == NW);
    check("t5_scan_en_cycles", en_cnt[0] == NW * W);

`ifdef SCAN_RX_CHECKSUM_EN
    for (int i = 0; i < NW; i++) wts[0][i] = 26'h3FFFFFF;
    start_scan(0);
    wait_done(0, 300);
    check("t6_checksum", chk1 === 32'hFFFFFFFC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
